icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 24, meaning the number of significant byte-address bits; icache_addr[31:ADDR_WIDTH] is ignored.
REQ-002 The block SHALL have parameter NUM_LINES, default 64, meaning the number of direct-mapped lines (power of 2).
REQ-003 The block SHALL have parameter LINE_WORDS, default 4, meaning the number of 32-bit words per line (power of 2, at least 2).
REQ-004 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 icache_req  input  1  core fetch request, held until icache_ready.
REQ-008 icache_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-009 icache_rdata  output  32  instruction word, valid only while icache_ready=1.
REQ-010 icache_ready  output  1  single-cycle response strobe.
REQ-011 flush  input  1  invalidate-all pulse.
REQ-012 mem_req  output  1  refill request, held high for the whole burst.
REQ-013 mem_addr  output  32  line-aligned refill base address, zero-extended above ADDR_WIDTH.
REQ-014 mem_rdata  input  32  refill data beat.
REQ-015 mem_valid  input  1  beat strobe; beats arrive in order, word 0 first.
REQ-016 hit_count, miss_count  output  32 each  statistics counters (see Configuration).

Function
REQ-017 Address split SHALL be: offset = addr[2+log2(LINE_WORDS)-1:2]; index = next log2(NUM_LINES) bits; tag = remaining bits up to ADDR_WIDTH-1.
REQ-018 The FSM SHALL have states IDLE, LOOKUP, REFILL and RESPOND.
REQ-019 In IDLE with icache_req=1 and no pending flush, the block SHALL latch the address and go to LOOKUP.
REQ-020 In LOOKUP on a hit (valid and tag match), the block SHALL drive icache_ready=1 with the addressed word that cycle and return to IDLE, giving a 2-cycle hit latency from req sampling.
REQ-021 In LOOKUP on a miss, the block SHALL go to REFILL with mem_req=1 and mem_addr = line base.
REQ-022 In REFILL, each mem_valid beat SHALL write the word at the beat counter position; after beat LINE_WORDS-1 the block SHALL set tag and valid, drop mem_req, and go to RESPOND.
REQ-023 In RESPOND, the block SHALL drive icache_ready=1 with the requested word and go to IDLE.
REQ-024 icache_ready SHALL never be high for more than one consecutive cycle; icache_req is not re-sampled until the cycle after ready.
REQ-025 mem_valid outside REFILL SHALL be ignored.
REQ-026 flush in IDLE SHALL clear all valid bits at the next edge, and icache_req SHALL be sampled on the following cycle.
REQ-027 flush in any other state SHALL be held pending; the current request SHALL complete, and the pending flush SHALL then be applied in IDLE before the next request is accepted.
REQ-028 icache_addr changing while a request is in flight SHALL have no effect on the in-flight request.

Reset
REQ-029 On reset the block SHALL enter IDLE, clear all valid bits, zero the beat counter and the pending flush, and drive icache_ready=0, mem_req=0, mem_addr=0 and icache_rdata=0.
REQ-030 Reset during REFILL SHALL abandon the burst, deassert mem_req on the next cycle, and leave the line invalid.

Configuration
REQ-031 With macro ICACHE_STATS_EN defined, hit_count SHALL increment on each LOOKUP hit and miss_count on each LOOKUP miss; both SHALL wrap at 2^32 and reset to 0.
REQ-032 Without ICACHE_STATS_EN, hit_count and miss_count SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-033 The state enum, the address-field width localparams and the field-extract helpers SHALL live in the shared package icache_pkg.
REQ-034 The data array SHALL be a sub-module, icache_data_ram: one write port and one read port, NUM_LINES*LINE_WORDS x 32 bits; tags and valid bits SHALL stay in icache.

Verification
REQ-035 Cold miss: req addr 0x000100; memory returns 0xA0,0xA1,0xA2,0xA3 -> mem_addr=0x000100, exactly 4 beats, then icache_ready with rdata=0xA0 and miss_count=1.
REQ-036 Hit after fill: req 0x000108 -> ready 2 cycles after req with rdata=0xA2, no mem_req, and hit_count=1.
REQ-037 Conflict: req 0x000500 (same index, different tag with defaults) -> refill occurs; a following req 0x000100 misses again.
REQ-038 Flush: flush asserted during REFILL of 0x000200 -> that response still returns the correct word; a following req 0x000200 misses.
REQ-039 Reset mid-burst: reset after 2 of 4 beats -> mem_req=0 next cycle; a req for the same line then performs a full 4-beat refill.
REQ-040 Stray beat: mem_valid=1 in IDLE with data 0xDEAD -> no array write; a later hit returns the original data.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_pkg                                                                 |
// | Shared FSM state type, default geometry and address field helpers.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_REFILL  = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    localparam int c_def_addr_width = 24;
    localparam int c_def_num_lines  = 64;
    localparam int c_def_line_words = 4;

    function automatic int offset_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int addr_width, input int idx_w, input int off_w);
        return addr_width - 2 - idx_w - off_w;
    endfunction

    // Keeps only the significant byte-address bits.
    function automatic logic [31:0] addr_mask(input logic [31:0] addr, input int addr_width);
        logic [63:0] m;
        m = (64'd1 << addr_width) - 64'd1;
        return addr & m[31:0];
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int off_w);
        return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_w,
                                               input int idx_w);
        return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int addr_width,
                                             input int lo_w);
        return addr_mask(addr, addr_width) >> (2 + lo_w);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] addr, input int addr_width,
                                              input int off_w);
        return addr_mask(addr, addr_width) & ~((32'd1 << (off_w + 2)) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_data_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_data_ram                                                            |
// | Instruction data array: one write port, one registered read port.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_data_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache                                                                     |
// | Direct-mapped instruction cache with burst refill and flush.               |
// | Optional hit/miss statistics counters: define ICACHE_STATS_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int NUM_LINES  = c_def_num_lines,
    parameter int LINE_WORDS = c_def_line_words
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_rdata,
    output logic        icache_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int c_off_w  = offset_width(LINE_WORDS);
    localparam int c_idx_w  = index_width(NUM_LINES);
    localparam int c_tag_w  = tag_width(ADDR_WIDTH, c_idx_w, c_off_w);
    localparam int c_ram_aw = c_idx_w + c_off_w;
    localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(LINE_WORDS - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [31:0]          r_addr;
    logic [NUM_LINES-1:0] r_valid;
    logic [c_tag_w-1:0]   r_tag [NUM_LINES];
    logic [c_off_w-1:0]   r_beat;
    logic                 r_flush_pend;
    logic [31:0]          r_fill_word;

    logic [c_off_w-1:0]   w_req_off;
    logic [c_idx_w-1:0]   w_req_idx;
    logic [c_tag_w-1:0]   w_req_tag;
    logic [c_off_w-1:0]   w_in_off;
    logic [c_idx_w-1:0]   w_in_idx;
    logic                 w_hit;
    logic                 w_flush_now;
    logic                 w_beat;
    logic                 w_last_beat;
    logic [c_ram_aw-1:0]  w_raddr;
    logic [31:0]          w_ram_rdata;

    assign w_req_off = c_off_w'(addr_offset(r_addr, c_off_w));
    assign w_req_idx = c_idx_w'(addr_index(r_addr, c_off_w, c_idx_w));
    assign w_req_tag = c_tag_w'(addr_tag(r_addr, ADDR_WIDTH, c_idx_w + c_off_w));
    assign w_in_off  = c_off_w'(addr_offset(icache_addr, c_off_w));
    assign w_in_idx  = c_idx_w'(addr_index(icache_addr, c_off_w, c_idx_w));

    assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_flush_now = (r_state == ST_IDLE) && (flush || r_flush_pend);
    assign w_beat      = (r_state == ST_REFILL) && mem_valid;
    assign w_last_beat = w_beat && (r_beat == c_last_beat);

    // The read is issued from the live address in IDLE so the word is ready in LOOKUP.
    assign w_raddr = (r_state == ST_IDLE) ? {w_in_idx, w_in_off} : {w_req_idx, w_req_off};

    icache_data_ram #(
        .DEPTH  (NUM_LINES * LINE_WORDS),
        .ADDR_W (c_ram_aw)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_beat),
        .i_waddr ({w_req_idx, r_beat}),
        .i_wdata (mem_rdata),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        icache_ready = 1'b0;
        icache_rdata = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        case (r_state)
            ST_IDLE: begin
                if (!w_flush_now && icache_req) begin
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    icache_ready = 1'b1;
                    icache_rdata = w_ram_rdata;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = line_base(r_addr, ADDR_WIDTH, c_off_w);
                if (w_last_beat) begin
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                icache_ready = 1'b1;
                icache_rdata = r_fill_word;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_valid      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_fill_word  <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_flush_now) begin
                    r_valid      <= '0;
                    r_flush_pend <= 1'b0;
                end else if (icache_req) begin
                    r_addr <= icache_addr;
                end
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end

            // Capture the requested word from the beat stream to avoid a read-during-write.
            if (w_beat) begin
                if (r_beat == w_req_off) begin
                    r_fill_word <= mem_rdata;
                end
                if (w_last_beat) begin
                    r_valid[w_req_idx] <= 1'b1;
                    r_beat             <= '0;
                end else begin
                    r_beat <= r_beat + c_off_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_last_beat) begin
            r_tag[w_req_idx] <= w_req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_icache                                                                  |
// | Directed self-checking bench for the instruction cache.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_icache;

`ifdef ICACHE_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        icache_req = 1'b0;
    logic [31:0] icache_addr = '0;
    logic [31:0] icache_rdata;
    logic        icache_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hit = '0;
    logic [31:0] exp_miss = '0;

    logic [31:0] f_rdata;
    int          f_beats;
    bit          f_req_seen;
    logic [31:0] f_maddr;
    int          f_lat;
    bit          f_to;

    icache dut (
        .clk          (clk),
        .reset        (reset),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_rdata (icache_rdata),
        .icache_ready (icache_ready),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset      = 1'b1;
        icache_req = 1'b0;
        mem_valid  = 1'b0;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        exp_hit  = '0;
        exp_miss = '0;
    endtask

    // Issues one fetch and plays the memory side: line word i = base + i.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] base,
                         input int flush_beat, input bit scramble);
        f_rdata = '0; f_beats = 0; f_req_seen = 0; f_maddr = '0; f_lat = 1; f_to = 1;
        icache_addr = addr;
        icache_req  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            f_lat++;
            flush = 1'b0;
            if (scramble) icache_addr = ~addr;
            if (icache_ready) begin
                f_rdata = icache_rdata;
                f_to    = 0;
                break;
            end
            if (mem_req) begin
                f_req_seen = 1;
                f_maddr    = mem_addr;
                mem_valid  = 1'b1;
                mem_rdata  = base + 32'(f_beats);
                if (f_beats == flush_beat) flush = 1'b1;
                f_beats++;
            end else begin
                mem_valid = 1'b0;
            end
        end
        icache_req = 1'b0;
        mem_valid  = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (icache_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", icache_ready); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        n_tests++; if (icache_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", icache_rdata); end
        n_tests++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    endtask

    task automatic test_cold_miss();
        fetch(32'h0000_0100, 32'hA0, -1, 0);
        exp_miss++;
        n_tests++; if (f_to) begin n_fail++; $display("FAIL cold_timeout no ready"); end
        n_tests++; if (f_maddr !== 32'h0000_0100) begin n_fail++; $display("FAIL cold_mem_addr got=%h exp=00000100", f_maddr); end
        n_tests++; if (f_beats != 4) begin n_fail++; $display("FAIL cold_beats got=%0d exp=4", f_beats); end
        n_tests++; if (f_rdata !== 32'hA0) begin n_fail++; $display("FAIL cold_rdata got=%h exp=a0", f_rdata); end
        n_tests++; if (miss_count !== (c_stats ? exp_miss : 32'd0)) begin n_fail++; $display("FAIL cold_miss_count got=%0d exp=%0d", miss_count, c_stats ? exp_miss : 32'd0); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_mem_req_drop got=%b exp=0", mem_req); end
    endtask

    task automatic test_hit();
        fetch(32'h0000_0108, 32'hEE, -1, 0);
        exp_hit++;
        n_tests++; if (f_rdata !== 32'hA2) begin n_fail++; $display("FAIL hit_rdata got=%h exp=a2", f_rdata); end
        n_tests++; if (f_lat != 2) begin n_fail++; $display("FAIL hit_latency got=%0d exp=2", f_lat); end
        n_tests++; if (f_req_seen) begin n_fail++; $display("FAIL hit_mem_req got=1 exp=0"); end
        n_tests++; if (hit_count !== (c_stats ? exp_hit : 32'd0)) begin n_fail++; $display("FAIL hit_count got=%0d exp=%0d", hit_count, c_stats ? exp_hit : 32'd0); end
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0500, 32'hB0, -1, 0);
        exp_miss++;
        n_tests++; if (!f_req_seen || f_maddr !== 32'h0000_0500) begin n_fail++; $display("FAIL conflict_refill got=%0d/%h exp=1/00000500", f_req_seen, f_maddr); end
        n_tests++; if (f_rdata !== 32'hB0) begin n_fail++; $display("FAIL conflict_rdata got=%h exp=b0", f_rdata); end
        fetch(32'h0000_0100, 32'hA0, -1, 0);
        exp_miss++;
        n_tests++; if (!f_req_seen || f_beats != 4) begin n_fail++; $display("FAIL conflict_remiss got=%0d/%0d exp=1/4", f_req_seen, f_beats); end
        n_tests++; if (f_rdata !== 32'hA0) begin n_fail++; $display("FAIL conflict_rdata2 got=%h exp=a0", f_rdata); end
        n_tests++; if (miss_count !== (c_stats ? exp_miss : 32'd0)) begin n_fail++; $display("FAIL conflict_miss_count got=%0d exp=%0d", miss_count, c_stats ? exp_miss : 32'd0); end
    endtask

    task automatic test_flush_refill();
        fetch(32'h0000_020C, 32'hC0, 1, 0);
        exp_miss++;
        n_tests++; if (f_rdata !== 32'hC3) begin n_fail++; $display("FAIL flush_refill_rdata got=%h exp=c3", f_rdata); end
        fetch(32'h0000_0200, 32'hC0, -1, 0);
        exp_miss++;
        n_tests++; if (!f_req_seen) begin n_fail++; $display("FAIL flush_refill_remiss got=0 exp=1"); end
        n_tests++; if (f_rdata !== 32'hC0) begin n_fail++; $display("FAIL flush_refill_rdata2 got=%h exp=c0", f_rdata); end
    endtask

    task automatic test_flush_idle();
        fetch(32'h0000_0300, 32'hD0, -1, 0);
        fetch(32'h0000_0300, 32'hD0, -1, 0);
        exp_miss++; exp_hit++;
        n_tests++; if (f_req_seen || f_rdata !== 32'hD0) begin n_fail++; $display("FAIL flush_idle_prehit got=%0d/%h exp=0/d0", f_req_seen, f_rdata); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch(32'h0000_0300, 32'hD0, -1, 0);
        exp_miss++;
        n_tests++; if (!f_req_seen) begin n_fail++; $display("FAIL flush_idle_remiss got=0 exp=1"); end
        n_tests++; if (hit_count !== (c_stats ? exp_hit : 32'd0)) begin n_fail++; $display("FAIL flush_idle_hit_count got=%0d exp=%0d", hit_count, c_stats ? exp_hit : 32'd0); end
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        bit seen;
        beats = 0;
        seen  = 0;
        icache_addr = 32'h0000_0600;
        icache_req  = 1'b1;
        for (int i = 0; i < 20 && beats < 2; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen      = 1;
                mem_valid = 1'b1;
                mem_rdata = 32'hE0 + 32'(beats);
                beats++;
            end
        end
        @(negedge clk);
        n_tests++; if (!seen || mem_req !== 1'b1) begin n_fail++; $display("FAIL midburst_active got=%0d/%b exp=1/1", seen, mem_req); end
        mem_valid  = 1'b0;
        icache_req = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        exp_hit  = '0;
        exp_miss = '0;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midburst_mem_req got=%b exp=0", mem_req); end
        fetch(32'h0000_0600, 32'hE0, -1, 0);
        exp_miss++;
        n_tests++; if (!f_req_seen || f_beats != 4) begin n_fail++; $display("FAIL midburst_refill got=%0d/%0d exp=1/4", f_req_seen, f_beats); end
        n_tests++; if (f_rdata !== 32'hE0) begin n_fail++; $display("FAIL midburst_rdata got=%h exp=e0", f_rdata); end
        n_tests++; if (miss_count !== (c_stats ? exp_miss : 32'd0)) begin n_fail++; $display("FAIL midburst_miss_count got=%0d exp=%0d", miss_count, c_stats ? exp_miss : 32'd0); end
    endtask

    task automatic test_stray_beat();
        fetch(32'h0000_0700, 32'hF0, -1, 0);
        exp_miss++;
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD;
        repeat (3) @(negedge clk);
        mem_valid = 1'b0;
        fetch(32'h0000_0700, 32'h55, -1, 0);
        exp_hit++;
        n_tests++; if (f_req_seen) begin n_fail++; $display("FAIL stray_mem_req got=1 exp=0"); end
        n_tests++; if (f_rdata !== 32'hF0) begin n_fail++; $display("FAIL stray_rdata got=%h exp=f0", f_rdata); end
    endtask

    task automatic test_back_to_back();
        int  pulses;
        bit  prev;
        pulses = 0;
        prev   = 0;
        icache_addr = 32'h0000_0708;
        icache_req  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (icache_ready) begin
                pulses++;
                n_tests++; if (icache_rdata !== 32'hF2) begin n_fail++; $display("FAIL b2b_rdata got=%h exp=f2", icache_rdata); end
            end
            n_tests++; if (prev && icache_ready) begin n_fail++; $display("FAIL b2b_ready_width got=2 cycles exp=1"); end
            prev = icache_ready;
        end
        icache_req = 1'b0;
        @(negedge clk);
        exp_hit += 4;
        n_tests++; if (pulses != 4) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
        n_tests++; if (hit_count !== (c_stats ? exp_hit : 32'd0)) begin n_fail++; $display("FAIL b2b_hit_count got=%0d exp=%0d", hit_count, c_stats ? exp_hit : 32'd0); end
    endtask

    task automatic test_addr_change();
        fetch(32'h0000_0804, 32'h40, -1, 1);
        exp_miss++;
        n_tests++; if (f_maddr !== 32'h0000_0800) begin n_fail++; $display("FAIL addrchg_mem_addr got=%h exp=00000800", f_maddr); end
        n_tests++; if (f_rdata !== 32'h41) begin n_fail++; $display("FAIL addrchg_rdata got=%h exp=41", f_rdata); end
        n_tests++; if (miss_count !== (c_stats ? exp_miss : 32'd0)) begin n_fail++; $display("FAIL addrchg_miss_count got=%0d exp=%0d", miss_count, c_stats ? exp_miss : 32'd0); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_refill();
        test_flush_idle();
        test_reset_mid_burst();
        test_stray_beat();
        test_back_to_back();
        test_addr_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
